alu_exec_ctrl: RTL and testbench

Multi-cycle execute-stage controller that drives the 32-bit ALU from the initiator side. It accepts one decoded-register instruction at a time over a valid/ready handshake and generates the ALU operand and 4-bit operation codes. It captures the ALU result and zero flag, then presents a writeback/branch result over a second valid/ready handshake. It sits between the register-read stage and the writeback/PC-update logic of the MIPS32 datapath.

---
 rtl/alu_exec_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller that decodes one MIPS32
// instruction, drives an external ALU and presents writeback/branch results.
module alu_exec_ctrl (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [31:0] Instr,
   input  logic [31:0] Rs_Data,
   input  logic [31:0] Rt_Data,
   input  logic [31:0] Pc,
   output logic [31:0] Op_1,
   output logic [31:0] Op_2,
   output logic [3:0]  Op_Alu,
   input  logic [31:0] Res,
   input  logic        ZF,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic        Wr_En,
   output logic [4:0]  Wr_Reg,
   output logic [31:0] Wr_Data,
   output logic        Br_Taken,
   output logic [31:0] Br_Target,
   output logic        Illegal
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      K_ALU = 2'd0,
      K_BEQ = 2'd1,
      K_BNE = 2'd2,
      K_ILL = 2'd3
   } kind_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   state_t state;
   state_t state_nxt;
   kind_t  kind;
   kind_t  d_kind;

   logic        accept;
   logic [5:0]  opc;
   logic [5:0]  fn;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sh;
   logic [15:0] imm;
   logic [31:0] imm_se;
   logic [31:0] imm_ze;
   logic [31:0] br_tgt;
   logic        unused_rs;

   logic [3:0]  r_alu;
   logic        r_ok;
   logic [3:0]  i_alu;
   logic [31:0] i_op2;
   logic        i_ok;

   logic [31:0] d_op1;
   logic [31:0] d_op2;
   logic [3:0]  d_alu;
   logic [4:0]  d_wr_reg;
   logic        d_wr_en;

   assign opc    = Instr[31:26];
   assign rt     = Instr[20:16];
   assign rd     = Instr[15:11];
   assign sh     = Instr[10:6];
   assign fn     = Instr[5:0];
   assign imm    = Instr[15:0];
   assign imm_se = {{16{imm[15]}}, imm};
   assign imm_ze = {16'h0000, imm};
   assign br_tgt = Pc + 32'd4 + {imm_se[29:0], 2'b00};

   // rs arrives pre-read as Rs_Data; the index itself is not needed
   assign unused_rs = ^Instr[25:21];

   assign accept = (state == IDLE) && In_Valid;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (In_Valid) state_nxt = EXEC;
         EXEC:    state_nxt = DONE;
         DONE:    if (Out_Ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      In_Ready  = (state == IDLE);
      Out_Valid = (state == DONE);
   end

   always_comb begin
      r_alu = ALU_ADD;
      r_ok  = 1'b1;
      unique case (1'b1)
         fn == F_ADD: r_alu = ALU_ADD;
         fn == F_SUB: r_alu = ALU_SUB;
         fn == F_AND: r_alu = ALU_AND;
         fn == F_OR:  r_alu = ALU_OR;
         fn == F_SLT: r_alu = ALU_SLT;
         (fn == F_SLL) && (sh == 5'd1):
            r_alu = ALU_SLL;
         default: r_ok = 1'b0;
      endcase
   end

   always_comb begin
      i_alu = ALU_ADD;
      i_op2 = imm_se;
      i_ok  = 1'b1;
      unique case (1'b1)
         opc == OP_ADDI: i_alu = ALU_ADD;
         opc == OP_SLTI: i_alu = ALU_SLT;
         opc == OP_ANDI: begin
            i_alu = ALU_AND;
            i_op2 = imm_ze;
         end
         opc == OP_ORI: begin
            i_alu = ALU_OR;
            i_op2 = imm_ze;
         end
         default: i_ok = 1'b0;
      endcase
   end

   always_comb begin
      d_op1    = '0;
      d_op2    = '0;
      d_alu    = ALU_ADD;
      d_wr_reg = '0;
      d_wr_en  = 1'b0;
      d_kind   = K_ILL;
      unique case (1'b1)
         (opc == OP_RTYPE) && r_ok: begin
            d_op1    = Rs_Data;
            d_op2    = Rt_Data;
            d_alu    = r_alu;
            d_wr_reg = rd;
            d_wr_en  = 1'b1;
            d_kind   = K_ALU;
         end
         i_ok: begin
            d_op1    = Rs_Data;
            d_op2    = i_op2;
            d_alu    = i_alu;
            d_wr_reg = rt;
            d_wr_en  = 1'b1;
            d_kind   = K_ALU;
         end
         (opc == OP_BEQ) || (opc == OP_BNE): begin
            d_op1  = Rs_Data;
            d_op2  = Rt_Data;
            d_alu  = ALU_SUB;
            d_kind = (opc == OP_BEQ) ? K_BEQ : K_BNE;
         end
         default: ;
      endcase
   end

   // decode fields load on accept; ALU outcome loads at the end of EXEC
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         Op_1      <= '0;
         Op_2      <= '0;
         Op_Alu    <= ALU_ADD;
         Wr_En     <= 1'b0;
         Wr_Reg    <= '0;
         Wr_Data   <= '0;
         Br_Taken  <= 1'b0;
         Br_Target <= '0;
         Illegal   <= 1'b0;
         kind      <= K_ALU;
      end else begin
         if (accept) begin
            Op_1      <= d_op1;
            Op_2      <= d_op2;
            Op_Alu    <= d_alu;
            Wr_En     <= d_wr_en;
            Wr_Reg    <= d_wr_reg;
            Br_Target <= br_tgt;
            Illegal   <= (d_kind == K_ILL);
            kind      <= d_kind;
         end
         if (state == EXEC) begin
            Wr_Data  <= Res;
            Br_Taken <= ((kind == K_BEQ) && ZF) ||
                        ((kind == K_BNE) && !ZF);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed plus randomized checks of alu_exec_ctrl
// against an instruction-level reference model.
module tb_alu_exec_ctrl;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [31:0] Instr = '0;
   logic [31:0] Rs_Data = '0;
   logic [31:0] Rt_Data = '0;
   logic [31:0] Pc = '0;
   logic [31:0] Op_1;
   logic [31:0] Op_2;
   logic [3:0]  Op_Alu;
   logic [31:0] Res;
   logic        ZF;
   logic        Out_Valid;
   logic        Out_Ready = 1'b0;
   logic        Wr_En;
   logic [4:0]  Wr_Reg;
   logic [31:0] Wr_Data;
   logic        Br_Taken;
   logic [31:0] Br_Target;
   logic        Illegal;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  alu;
      logic        wr_en;
      logic [4:0]  wr_reg;
      logic [31:0] wr_data;
      logic        br;
      logic [31:0] tgt;
      logic        ill;
   } exp_t;

   alu_exec_ctrl dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .In_Valid(In_Valid), .In_Ready(In_Ready),
      .Instr(Instr), .Rs_Data(Rs_Data),
      .Rt_Data(Rt_Data), .Pc(Pc),
      .Op_1(Op_1), .Op_2(Op_2), .Op_Alu(Op_Alu),
      .Res(Res), .ZF(ZF),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Wr_En(Wr_En), .Wr_Reg(Wr_Reg),
      .Wr_Data(Wr_Data), .Br_Taken(Br_Taken),
      .Br_Target(Br_Target), .Illegal(Illegal)
   );

   always #5 Clk = ~Clk;

   // the ALU that sits on the far side of the controller
   always_comb begin
      Res = '0;
      case (Op_Alu)
         4'b0010: Res = Op_1 + Op_2;
         4'b0110: Res = Op_1 - Op_2;
         4'b0000: Res = Op_1 & Op_2;
         4'b0001: Res = Op_1 | Op_2;
         4'b0111: Res = (Op_1 < Op_2) ? 32'd1 : 32'd0;
         4'b1111: Res = Op_2 << 1;
         default: Res = '0;
      endcase
   end
   assign ZF = (Res == 32'd0);

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ins,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] pc);
      exp_t e;
      logic [31:0] se;
      logic [31:0] ze;
      logic ok;
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0000, ins[15:0]};
      ok = 1'b1;
      e.op1 = a;
      e.op2 = b;
      e.alu = 4'b0010;
      e.wr_en = 1'b1;
      e.wr_reg = ins[20:16];
      e.wr_data = '0;
      e.br = 1'b0;
      e.tgt = pc + 32'd4 + se * 32'd4;
      e.ill = 1'b0;
      case (ins[31:26])
         6'h00: begin
            e.wr_reg = ins[15:11];
            case (ins[5:0])
               6'h20: begin e.alu = 4'b0010; e.wr_data = a + b; end
               6'h22: begin e.alu = 4'b0110; e.wr_data = a - b; end
               6'h24: begin e.alu = 4'b0000; e.wr_data = a & b; end
               6'h25: begin e.alu = 4'b0001; e.wr_data = a | b; end
               6'h2A: begin e.alu = 4'b0111; e.wr_data = {31'b0, a < b}; end
               6'h00: begin
                  ok = (ins[10:6] == 5'd1);
                  e.alu = 4'b1111;
                  e.wr_data = b << 1;
               end
               default: ok = 1'b0;
            endcase
         end
         6'h08: begin e.op2 = se; e.wr_data = a + se; end
         6'h0A: begin e.op2 = se; e.alu = 4'b0111; e.wr_data = {31'b0, a < se}; end
         6'h0C: begin e.op2 = ze; e.alu = 4'b0000; e.wr_data = a & ze; end
         6'h0D: begin e.op2 = ze; e.alu = 4'b0001; e.wr_data = a | ze; end
         6'h04, 6'h05: begin
            e.alu = 4'b0110;
            e.wr_en = 1'b0;
            e.wr_data = a - b;
            e.br = (ins[26] == 1'b0) ? (a == b) : (a != b);
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.op1 = '0;
         e.op2 = '0;
         e.alu = 4'b0010;
         e.wr_en = 1'b0;
         e.wr_data = '0;
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic check_res(input exp_t e);
      check("wr_en", 32'(Wr_En), 32'(e.wr_en));
      if (e.wr_en) check("wr_reg", 32'(Wr_Reg), 32'(e.wr_reg));
      check("wr_data", Wr_Data, e.wr_data);
      check("br_taken", 32'(Br_Taken), 32'(e.br));
      check("br_target", Br_Target, e.tgt);
      check("illegal", 32'(Illegal), 32'(e.ill));
   endtask

   task automatic check_ops(input string tag, input exp_t e);
      check({tag, "_op_1"}, Op_1, e.op1);
      check({tag, "_op_2"}, Op_2, e.op2);
      check({tag, "_op_alu"}, 32'(Op_Alu), 32'(e.alu));
   endtask

   task automatic check_reset();
      check("rst_in_ready", 32'(In_Ready), 32'd1);
      check("rst_out_valid", 32'(Out_Valid), 32'd0);
      check("rst_op_1", Op_1, 32'd0);
      check("rst_op_2", Op_2, 32'd0);
      check("rst_op_alu", 32'(Op_Alu), 32'd2);
      check("rst_wr_en", 32'(Wr_En), 32'd0);
      check("rst_wr_reg", 32'(Wr_Reg), 32'd0);
      check("rst_wr_data", Wr_Data, 32'd0);
      check("rst_br_taken", 32'(Br_Taken), 32'd0);
      check("rst_br_target", Br_Target, 32'd0);
      check("rst_illegal", 32'(Illegal), 32'd0);
   endtask

   // present one instruction, follow it to DONE, hold, then release
   task automatic run(input logic [31:0] ins,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] pc,
                      input int hold);
      exp_t e;
      int lat;
      e = model(ins, a, b, pc);
      check("in_ready_idle", 32'(In_Ready), 32'd1);
      Instr = ins;
      Rs_Data = a;
      Rt_Data = b;
      Pc = pc;
      In_Valid = 1'b1;
      @(posedge Clk); #1;
      In_Valid = 1'b0;
      Instr = $urandom;
      Rs_Data = $urandom;
      Rt_Data = $urandom;
      Pc = $urandom;
      Out_Ready = 1'($urandom);
      check_ops("exec", e);
      check("in_ready_exec", 32'(In_Ready), 32'd0);
      check("out_valid_exec", 32'(Out_Valid), 32'd0);
      // cycles counted from the cycle the instruction was presented
      lat = 1;
      while (!Out_Valid && lat < 8) begin
         @(posedge Clk); #1;
         lat++;
      end
      Out_Ready = 1'b0;
      check("latency", 32'(lat), 32'd2);
      check_res(e);
      for (int k = 0; k < hold; k++) begin
         In_Valid = 1'($urandom);
         Instr = $urandom;
         Rs_Data = $urandom;
         @(posedge Clk); #1;
         check("hold_out_valid", 32'(Out_Valid), 32'd1);
         check("hold_in_ready", 32'(In_Ready), 32'd0);
         check_ops("hold", e);
         check_res(e);
      end
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      @(posedge Clk); #1;
      Out_Ready = 1'b0;
      check("ret_out_valid", 32'(Out_Valid), 32'd0);
      check("ret_in_ready", 32'(In_Ready), 32'd1);
      check_ops("idle", e);
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2: begin
            w[31:26] = 6'h00;
            case ($urandom_range(0, 5))
               0: w[5:0] = 6'h20;
               1: w[5:0] = 6'h22;
               2: w[5:0] = 6'h24;
               3: w[5:0] = 6'h25;
               4: w[5:0] = 6'h2A;
               default: w[5:0] = 6'h00;
            endcase
            w[10:6] = (w[5:0] == 6'h00) ? 5'($urandom_range(0, 3)) : 5'd0;
         end
         3, 4: begin
            case ($urandom_range(0, 3))
               0: w[31:26] = 6'h08;
               1: w[31:26] = 6'h0A;
               2: w[31:26] = 6'h0C;
               default: w[31:26] = 6'h0D;
            endcase
         end
         5, 6: w[31:26] = 6'h04 | 6'($urandom_range(0, 1));
         7: begin
            w[31:26] = 6'h00;
            w[10:6] = 5'd0;
         end
         default: if (w[31:26] == 6'h00) w[31:26] = 6'h3F;
      endcase
      return w;
   endfunction

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ins;

      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      check_reset();

      run(32'h00221820, 32'd5, 32'd7, 32'h0, 0);
      run({6'h04, 5'd1, 5'd2, 16'h0004}, 32'd9, 32'd9, 32'h100, 0);
      run({6'h05, 5'd1, 5'd2, 16'h0004}, 32'd9, 32'd9, 32'h100, 0);
      run({6'h08, 5'd1, 5'd4, 16'hFFFF}, 32'd3, 32'd0, 32'h40, 0);
      run({6'h0D, 5'd0, 5'd5, 16'h8000}, 32'd0, 32'd0, 32'h44, 0);
      run({6'h00, 5'd0, 5'd2, 5'd3, 5'd1, 6'h00},
          32'h0, 32'h40000001, 32'h48, 0);
      run({6'h00, 5'd0, 5'd2, 5'd3, 5'd2, 6'h00},
          32'h0, 32'h40000001, 32'h4C, 0);
      run({6'h04, 5'd1, 5'd2, 16'hFFFE}, 32'd1, 32'd1, 32'h200, 0);
      run(32'h00221822, 32'd3, 32'd5, 32'h0, 5);

      // reset while EXEC
      Instr = 32'h00221820;
      Rs_Data = 32'd5;
      Rt_Data = 32'd7;
      In_Valid = 1'b1;
      @(posedge Clk); #1;
      In_Valid = 1'b0;
      Rst_n = 1'b0;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      check_reset();
      repeat (3) begin
         @(posedge Clk); #1;
         check("exec_rst_no_valid", 32'(Out_Valid), 32'd0);
      end
      run(32'h00221820, 32'd10, 32'd20, 32'h0, 0);

      // reset while DONE
      In_Valid = 1'b1;
      @(posedge Clk); #1;
      In_Valid = 1'b0;
      @(posedge Clk); #1;
      Rst_n = 1'b0;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      check_reset();

      // reset on the same edge as a handshake
      Instr = {6'h0D, 5'd0, 5'd5, 16'h1234};
      In_Valid = 1'b1;
      Rst_n = 1'b0;
      @(posedge Clk); #1;
      In_Valid = 1'b0;
      Rst_n = 1'b1;
      check_reset();
      @(posedge Clk); #1;
      check("hs_rst_no_valid", 32'(Out_Valid), 32'd0);
      check("hs_rst_in_ready", 32'(In_Ready), 32'd1);

      for (int i = 0; i < 200; i++) begin
         ins = gen();
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run(ins, a, b, $urandom, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
